// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: ALU op codes used by the HI/LO path, FSM state encoding
// and op-class helper functions shared by the HI/LO unit.
package hilo_unit_pkg;

  // ALU op codes seen on ex_op that matter to the HI/LO path
  localparam logic [4:0] SIG_ALU_MULT  = 5'h18;
  localparam logic [4:0] SIG_ALU_MULTU = 5'h19;
  localparam logic [4:0] SIG_ALU_DIV   = 5'h1A;
  localparam logic [4:0] SIG_ALU_DIVU  = 5'h1B;
  localparam logic [4:0] SIG_ALU_MFHI  = 5'h1C;
  localparam logic [4:0] SIG_ALU_MFLO  = 5'h1D;
  localparam logic [4:0] SIG_ALU_MTHI  = 5'h1E;
  localparam logic [4:0] SIG_ALU_MTLO  = 5'h1F;

  // Mul/div sequencing states
  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_BUSY = 2'd1,
    HILO_HOLD = 2'd2
  } hilo_state_t;

  // Multi-cycle ops that return a full {hi,lo} result
  function automatic logic op_is_md(input logic [4:0] op);
    return (op == SIG_ALU_MULT) || (op == SIG_ALU_MULTU) ||
           (op == SIG_ALU_DIV)  || (op == SIG_ALU_DIVU);
  endfunction

  // Ops that read HI or LO
  function automatic logic op_is_mf(input logic [4:0] op);
    return (op == SIG_ALU_MFHI) || (op == SIG_ALU_MFLO);
  endfunction

endpackage

// File: rtl/hilo_unit_regfile.sv
// hilo_regfile: architectural HI and LO registers with independent write
// enables so MTHI/MTLO touch only their own half.
module hilo_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // HI half: updated only when its enable is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_hi <= '0;
    else if (i_hi_we) r_hi <= i_hi;
  end

  // LO half: updated only when its enable is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_lo <= '0;
    else if (i_lo_we) r_lo <= i_lo;
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO EX->M->commit path behind the ALU. Sequences mul/div
// results (wait / hold-under-stall), issues MTHI/MTLO directly, and
// forwards HI/LO back to the ALU.
// Build option: HILO_BYPASS_EN -- when defined, forward from the M stage;
// when undefined, forward architectural HI/LO only and interlock MFHI/MFLO
// behind a pending M write.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall_in,
  input  logic               ex_valid,
  input  logic [4:0]         ex_op,
  input  logic [WIDTH-1:0]   ex_rs,
  input  logic [2*WIDTH-1:0] alu_hilo,
  input  logic               alu_busy,
  input  logic               alu_ok,
  output logic [2*WIDTH-1:0] hilo_fwd,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               stall_req
);

  hilo_state_t      r_state;
  hilo_state_t      w_nxt;
  logic [2*WIDTH-1:0] r_hold;

  // M-stage entry
  logic             r_m_hi_we;
  logic             r_m_lo_we;
  logic [WIDTH-1:0] r_m_hi;
  logic [WIDTH-1:0] r_m_lo;

  // Issue toward M and hold-capture strobes
  logic             w_iss_hi_we;
  logic             w_iss_lo_we;
  logic [WIDTH-1:0] w_iss_hi;
  logic [WIDTH-1:0] w_iss_lo;
  logic             w_cap;
  logic             w_stall_fsm;

  logic w_md, w_mthi, w_mtlo, w_mf;
  logic w_commit_hi, w_commit_lo;
  logic [WIDTH-1:0] w_fwd_hi, w_fwd_lo;

  // ALU busy is implied by the BUSY state; the flag itself is not needed
  logic w_unused;
  assign w_unused = alu_busy;

  assign w_md   = ex_valid & op_is_md(ex_op);
  assign w_mthi = ex_valid & (ex_op == SIG_ALU_MTHI);
  assign w_mtlo = ex_valid & (ex_op == SIG_ALU_MTLO);
  assign w_mf   = ex_valid & op_is_mf(ex_op);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= HILO_IDLE;
    else      r_state <= w_nxt;
  end

  // FSM next state: flush always returns to IDLE
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      HILO_IDLE: begin
        if (!flush && w_md) begin
          if (!alu_ok)      w_nxt = HILO_BUSY;
          else if (stall_in) w_nxt = HILO_HOLD;
        end
      end
      HILO_BUSY: begin
        if (flush)       w_nxt = HILO_IDLE;
        else if (alu_ok) w_nxt = stall_in ? HILO_HOLD : HILO_IDLE;
      end
      HILO_HOLD: begin
        if (flush || !stall_in) w_nxt = HILO_IDLE;
      end
      default: w_nxt = HILO_IDLE;
    endcase
  end

  // FSM outputs: what goes to M this cycle, hold capture, stall request
  always_comb begin
    w_iss_hi_we = 1'b0;
    w_iss_lo_we = 1'b0;
    w_iss_hi    = alu_hilo[2*WIDTH-1:WIDTH];
    w_iss_lo    = alu_hilo[WIDTH-1:0];
    w_cap       = 1'b0;
    w_stall_fsm = 1'b0;
    case (r_state)
      HILO_IDLE: begin
        if (!flush) begin
          if (w_md) begin
            if (!alu_ok) begin
              w_stall_fsm = 1'b1;
            end else if (stall_in) begin
              w_cap       = 1'b1;
              w_stall_fsm = 1'b1;
            end else begin
              w_iss_hi_we = 1'b1;
              w_iss_lo_we = 1'b1;
            end
          end else if (w_mthi) begin
            w_iss_hi_we = 1'b1;
            w_iss_hi    = ex_rs;
          end else if (w_mtlo) begin
            w_iss_lo_we = 1'b1;
            w_iss_lo    = ex_rs;
          end
        end
      end
      HILO_BUSY: begin
        w_stall_fsm = 1'b1;
        if (!flush && alu_ok) begin
          if (stall_in) begin
            w_cap = 1'b1;
          end else begin
            w_iss_hi_we = 1'b1;
            w_iss_lo_we = 1'b1;
          end
        end
      end
      HILO_HOLD: begin
        // stall_req drops in the same cycle the held value leaves
        w_stall_fsm = stall_in;
        w_iss_hi    = r_hold[2*WIDTH-1:WIDTH];
        w_iss_lo    = r_hold[WIDTH-1:0];
        if (!flush && !stall_in) begin
          w_iss_hi_we = 1'b1;
          w_iss_lo_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Hold register: keeps a finished result while downstream is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_hold <= '0;
    else if (flush) r_hold <= '0;
    else if (w_cap) r_hold <= alu_hilo;
  end

  // M stage: loads the issued entry (or a bubble) unless stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_hi_we <= 1'b0;
      r_m_lo_we <= 1'b0;
      r_m_hi    <= '0;
      r_m_lo    <= '0;
    end else if (!stall_in) begin
      r_m_hi_we <= w_iss_hi_we;
      r_m_lo_we <= w_iss_lo_we;
      r_m_hi    <= w_iss_hi;
      r_m_lo    <= w_iss_lo;
    end
  end

  // Commit uses the current M entry; a new load on the same edge is fine
  assign w_commit_hi = r_m_hi_we & ~stall_in;
  assign w_commit_lo = r_m_lo_we & ~stall_in;

  hilo_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .i_hi_we (w_commit_hi),
    .i_lo_we (w_commit_lo),
    .i_hi    (r_m_hi),
    .i_lo    (r_m_lo),
    .o_hi    (hi_o),
    .o_lo    (lo_o)
  );

`ifdef HILO_BYPASS_EN
  assign w_fwd_hi  = r_m_hi_we ? r_m_hi : hi_o;
  assign w_fwd_lo  = r_m_lo_we ? r_m_lo : lo_o;
  assign stall_req = w_stall_fsm;
`else
  // No bypass: a reader waits until the pending M entry has committed
  assign w_fwd_hi  = hi_o;
  assign w_fwd_lo  = lo_o;
  assign stall_req = w_stall_fsm | (w_mf & (r_m_hi_we | r_m_lo_we));
`endif

  assign hilo_fwd = {w_fwd_hi, w_fwd_lo};

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, stall_in = 1'b0, ex_valid = 1'b0;
  logic [4:0]    ex_op = 5'h0;
  logic [W-1:0]  ex_rs = '0;
  logic [2*W-1:0] alu_hilo = '0;
  logic          alu_busy = 1'b0, alu_ok = 1'b0;
  logic [2*W-1:0] hilo_fwd;
  logic [W-1:0]  hi_o, lo_o;
  logic          stall_req;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .alu_hilo(alu_hilo), .alu_busy(alu_busy), .alu_ok(alu_ok),
    .hilo_fwd(hilo_fwd), .hi_o(hi_o), .lo_o(lo_o), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_wait, m_held;
  logic [63:0] m_hv;
  bit          mh_we, ml_we;
  logic [31:0] mh, ml, ah, al;

  function automatic bit is_md(input logic [4:0] op);
    return op == SIG_ALU_MULT || op == SIG_ALU_MULTU ||
           op == SIG_ALU_DIV  || op == SIG_ALU_DIVU;
  endfunction

  function automatic bit is_mf(input logic [4:0] op);
    return op == SIG_ALU_MFHI || op == SIG_ALU_MFLO;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit ihw, ilw;
    logic [31:0] ih, il;
    if (!rst) begin
      m_wait = 0; m_held = 0; m_hv = '0;
      mh_we = 0; ml_we = 0; mh = '0; ml = '0; ah = '0; al = '0;
    end else begin
      ihw = 0; ilw = 0; ih = 0; il = 0;
      if (m_held) begin
        if (flush) m_held = 0;
        else if (!stall_in) begin
          ihw = 1; ilw = 1; ih = m_hv[63:32]; il = m_hv[31:0]; m_held = 0;
        end
      end else if (m_wait) begin
        if (flush) m_wait = 0;
        else if (alu_ok) begin
          m_wait = 0;
          if (stall_in) begin m_held = 1; m_hv = alu_hilo; end
          else begin ihw = 1; ilw = 1; ih = alu_hilo[63:32]; il = alu_hilo[31:0]; end
        end
      end else if (!flush && ex_valid) begin
        if (is_md(ex_op)) begin
          if (!alu_ok) m_wait = 1;
          else if (stall_in) begin m_held = 1; m_hv = alu_hilo; end
          else begin ihw = 1; ilw = 1; ih = alu_hilo[63:32]; il = alu_hilo[31:0]; end
        end else if (ex_op == SIG_ALU_MTHI) begin ihw = 1; ih = ex_rs; end
        else if (ex_op == SIG_ALU_MTLO) begin ilw = 1; il = ex_rs; end
      end
      if (!stall_in) begin
        if (mh_we) ah = mh;
        if (ml_we) al = ml;
        mh_we = ihw; ml_we = ilw; mh = ih; ml = il;
      end
    end
  end

  function automatic bit exp_stall();
    bit e;
    if (m_held)      e = stall_in;
    else if (m_wait) e = 1;
    else e = ex_valid && is_md(ex_op) && !flush && (!alu_ok || stall_in);
`ifndef HILO_BYPASS_EN
    if (ex_valid && is_mf(ex_op) && (mh_we || ml_we)) e = 1;
`endif
    return e;
  endfunction

  function automatic logic [63:0] exp_fwd();
`ifdef HILO_BYPASS_EN
    return {mh_we ? mh : ah, ml_we ? ml : al};
`else
    return {ah, al};
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_hi", {32'h0, hi_o}, {32'h0, ah});
      chk("cmp_lo", {32'h0, lo_o}, {32'h0, al});
      chk("cmp_fwd", hilo_fwd, exp_fwd());
      chk("cmp_stall", {63'h0, stall_req}, {63'h0, exp_stall()});
    end
  end

  // One cycle of inputs: applied after an edge, returns mid-cycle
  task automatic drv(input bit v, input logic [4:0] op, input logic [31:0] rs,
                     input bit ok, input logic [63:0] hl, input bit st, input bit fl);
    @(posedge clk); #1;
    ex_valid = v; ex_op = op; ex_rs = rs; alu_ok = ok; alu_hilo = hl;
    stall_in = st; flush = fl; alu_busy = v && is_md(op) && !ok;
    @(negedge clk); #1;
  endtask

  task automatic nop();
    drv(0, 5'h01, 0, 0, 0, 0, 0);
  endtask

  logic [4:0] ops [9];

  initial begin
    ops = '{SIG_ALU_MULT, SIG_ALU_MULTU, SIG_ALU_DIV, SIG_ALU_DIVU,
            SIG_ALU_MTHI, SIG_ALU_MTLO, SIG_ALU_MFHI, SIG_ALU_MFLO, 5'h01};
    #12;
    chk("rst_hi", {32'h0, hi_o}, 64'h0);
    chk("rst_fwd", hilo_fwd, 64'h0);
    chk("rst_stall", {63'h0, stall_req}, 64'h0);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // MULT: 3 busy cycles, then result
    for (int i = 0; i < 3; i++) begin
      drv(1, SIG_ALU_MULT, 0, 0, 0, 0, 0);
      chk("mult_busy_stall", {63'h0, stall_req}, 64'h1);
    end
    drv(1, SIG_ALU_MULT, 0, 1, 64'h00000001_FFFFFFFE, 0, 0);
    nop();
    chk("mult_edge1_hi", {32'h0, hi_o}, 64'h0);
`ifdef HILO_BYPASS_EN
    chk("mult_edge1_fwd", hilo_fwd, 64'h00000001_FFFFFFFE);
`else
    chk("mult_edge1_fwd", hilo_fwd, 64'h0);
`endif
    nop();
    chk("mult_hi", {32'h0, hi_o}, 64'h1);
    chk("mult_lo", {32'h0, lo_o}, 64'hFFFFFFFE);

    // Result arrives under a 4-cycle downstream stall
    drv(1, SIG_ALU_MULT, 0, 0, 0, 0, 0);
    drv(1, SIG_ALU_MULT, 0, 1, 64'h00001234_00005678, 1, 0);
    chk("hold_stall0", {63'h0, stall_req}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      drv(1, SIG_ALU_MULT, 0, 0, 0, 1, 0);
      chk("hold_stall", {63'h0, stall_req}, 64'h1);
      chk("hold_nocommit", {32'h0, hi_o}, 64'h1);
    end
    drv(1, SIG_ALU_MULT, 0, 0, 0, 0, 0);
    chk("hold_release_stall", {63'h0, stall_req}, 64'h0);
    nop();
    nop();
    chk("hold_commit", {hi_o, lo_o}, 64'h00001234_00005678);

    // MTHI then MFHI
    drv(1, SIG_ALU_MTHI, 32'hDEADBEEF, 0, 0, 0, 0);
    drv(1, SIG_ALU_MFHI, 0, 0, 0, 0, 0);
`ifdef HILO_BYPASS_EN
    chk("mf_bypass_fwd", hilo_fwd, 64'hDEADBEEF_00005678);
    chk("mf_bypass_stall", {63'h0, stall_req}, 64'h0);
`else
    chk("mf_interlock_stall", {63'h0, stall_req}, 64'h1);
    chk("mf_interlock_fwd", hilo_fwd, 64'h00001234_00005678);
`endif
    drv(1, SIG_ALU_MFHI, 0, 0, 0, 0, 0);
    chk("mf_after_stall", {63'h0, stall_req}, 64'h0);
    chk("mf_after_fwd", hilo_fwd, 64'hDEADBEEF_00005678);

    // MTLO then MTHI back to back
    drv(1, SIG_ALU_MTLO, 32'h5, 0, 0, 0, 0);
    drv(1, SIG_ALU_MTHI, 32'h7, 0, 0, 0, 0);
    nop();
    chk("mtlo_hi_kept", {hi_o, lo_o}, 64'hDEADBEEF_00000005);
    nop();
    chk("mt_final", {hi_o, lo_o}, 64'h00000007_00000005);

    // Flush during BUSY, late alu_ok ignored
    drv(1, SIG_ALU_DIV, 0, 0, 0, 0, 0);
    drv(1, SIG_ALU_DIV, 0, 0, 0, 0, 1);
    drv(0, 5'h01, 0, 1, 64'hAAAA5555_12345678, 0, 0);
    chk("flush_stall", {63'h0, stall_req}, 64'h0);
    nop();
    nop();
    chk("flush_nocommit", {hi_o, lo_o}, 64'h00000007_00000005);

    // Async reset while holding
    drv(1, SIG_ALU_MTHI, 32'h1234, 0, 0, 0, 0);
    nop();
    nop();
    chk("pre_rst_hi", {32'h0, hi_o}, 64'h1234);
    drv(1, SIG_ALU_MULTU, 0, 1, 64'h11111111_22222222, 1, 0);
    drv(1, SIG_ALU_MULTU, 0, 0, 0, 1, 0);
    chk("pre_rst_stall", {63'h0, stall_req}, 64'h1);
    ex_valid = 0; stall_in = 0; alu_ok = 0;
    rst = 1'b0;
    #1;
    chk("async_rst", {hi_o, lo_o}, 64'h0);
    chk("async_rst_fwd", hilo_fwd, 64'h0);
    chk("async_rst_stall", {63'h0, stall_req}, 64'h0);
    #1 rst = 1'b1;
    nop();
    nop();
    chk("post_rst", {31'h0, stall_req, hi_o}, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(9, 0) < 8, ops[$urandom_range(8, 0)], $urandom,
          $urandom_range(9, 0) < 3, {$urandom, $urandom},
          $urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0);
    end
    nop();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO architectural register file and EX→commit pipeline for the HI/LO path; sits directly downstream of the ALU.
- Consumes the ALU's 64-bit mul/div result and its handshake flags, plus MTHI/MTLO data.
- Drives the ALU's HILO_i with forwarded HI/LO and raises a pipeline stall while mul/div is computing or a result is held.

Parameters:
- WIDTH, 32, width of HI and of LO.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  kill the EX-stage instruction
- stall_in  in  1  downstream stall; freezes the M stage and blocks commit
- ex_valid  in  1  EX instruction valid
- ex_op  in  5  ALU op code (SIG_ALU_*)
- ex_rs  in  WIDTH  rs operand, used by MTHI/MTLO
- alu_hilo  in  2*WIDTH  ALU HILO_o, {hi,lo}
- alu_busy  in  1  ALU isMulOrDivComputing
- alu_ok  in  1  ALU isMulOrDivResultOk, single-cycle pulse
- hilo_fwd  out  2*WIDTH  to ALU HILO_i, forwarded {hi,lo}
- hi_o  out  WIDTH  architectural HI
- lo_o  out  WIDTH  architectural LO
- stall_req  out  1  request a stall of IF/ID/EX

Behaviour:
Reset (rst=0, async):
- hi_o, lo_o, all M-stage registers and the hold register are 0.
- FSM is IDLE; stall_req=0; hilo_fwd=0.

Op classes:
- MD = MULT/MULTU/DIV/DIVU.
- MTHI writes HI only; MTLO writes LO only.
- Each M entry carries m_hi_we, m_lo_we, m_hi, m_lo.

FSM (states IDLE, BUSY, HOLD):
- IDLE, ex_valid & MD & ~alu_ok → BUSY; stall_req=1.
- IDLE, ex_valid & MD & alu_ok (same cycle):
  - if ~stall_in: issue to M directly.
  - if stall_in: capture alu_hilo into the hold register → HOLD.
- BUSY: stall_req=1.
  - on alu_ok & ~stall_in: issue alu_hilo to M → IDLE.
  - on alu_ok & stall_in: capture → HOLD.
- HOLD: stall_req=1; the hold register persists; the ALU is not re-triggered.
  - when ~stall_in: issue held value to M with both write enables → IDLE; stall_req falls the same cycle.
- flush in any state: → IDLE next edge, hold discarded, no M issue that cycle; the older M entry is unaffected.

M stage (1 edge after issue):
- Loads when ~stall_in.
- MTHI/MTLO issue in the same cycle as EX with no FSM involvement.
- Non-HI/LO ops or ~ex_valid load write enables = 0.
- With stall_in, M holds its contents.

Commit:
- On the edge where the M entry has any write enable & ~stall_in, write the enabled halves to hi_o/lo_o.
- Total latency from alu_ok (unstalled) to hi_o/lo_o visible: 2 edges.

Forwarding:
- hilo_fwd per half = M value if that half's M write enable is set, else architectural value.
- Purely combinational.

Simultaneous events:
- M commit and a new M load in the same edge are legal; commit uses the old M contents.
- stall_in takes priority over issue; flush takes priority over issue and hold.

Optional Feature:
- Macro HILO_BYPASS_EN.
- Defined: forwarding as above.
- Undefined: hilo_fwd = architectural {hi_o, lo_o} only. stall_req is additionally asserted while ex_valid & ex_op∈{MFHI, MFLO} and any M write enable is set, for exactly the cycles until that entry commits.

Decomposition:
- The SIG_ALU_MTHI and SIG_ALU_MTLO codes belong in define_alu_ctrl.vh.
- The FSM state constants (IDLE=2'd0, BUSY=2'd1, HOLD=2'd2) belong in a new define_hilo.vh.
- One sub-module: hilo_regfile (two WIDTH-bit registers with per-half write enables and async active-low reset).

Test Plan:
- MULT, alu_busy 3 cycles then alu_ok with alu_hilo=64'h00000001_FFFFFFFE, no stall → stall_req high 3 cycles, hi_o=32'h1 and lo_o=32'hFFFFFFFE 2 edges after alu_ok.
- alu_ok coincides with stall_in high for 4 cycles → FSM HOLD and stall_req high throughout. Single commit of the held value after release; alu_ok does not repeat.
- MTHI rs=32'hDEADBEEF followed by MFHI next cycle → hilo_fwd[63:32]=32'hDEADBEEF via M bypass, LO unchanged. Macro undefined: 1 stall cycle, then the architectural value.
- MTLO 32'h5 then MTHI 32'h7 back-to-back → commits in order, final {hi,lo}={7,5}; MTLO does not disturb HI.
- flush during BUSY and alu_ok the next cycle → no commit, hi_o/lo_o unchanged, FSM IDLE, stall_req 0.
- rst asserted during HOLD with a committed hi_o=32'h1234 → all outputs 0 immediately (async); resumes IDLE after rst deasserts.
